// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the request, response and memory-pin signals of mem_access_unit.
//   slave  : the view used by mem_access_unit itself (takes requests, drives memory pins).
//   master : the view of the environment (issues requests, consumes responses, returns mem_rdata).
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_len/req_wdata  request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                  response channel
//   busy                                                   unit not idle
//   mem_address/mem_write_en/mem_mode/mem_wdata/mem_rdata  data-memory pins
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_en;
  logic              mem_mode;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output mem_address, mem_write_en, mem_mode, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  mem_address, mem_write_en, mem_mode, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator for an address-event driven 32x32 data memory.
// Accepts load/store requests (loads may be bursts of req_len+1 words), drives the memory pins and
// returns one response per accessed word. Every access is preceded by one PARK cycle that drives
// the inverted address so the memory always sees an address change.
// Ports:
//   clk  clock, rst  synchronous active-high reset
//   bus  mem_access_unit_if.slave: request, response, busy and memory pins (all outputs registered)
// Build option: define STORE_ECHO_CHECK_EN to issue stores as STORE_ECHO and flag read-back
// mismatches on rsp_err; otherwise stores use plain STORE, return rdata 0 and rsp_err stays 0.
module mem_access_unit #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input logic             clk,
  input logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

`ifdef STORE_ECHO_CHECK_EN
  localparam bit EchoEn = 1'b1;
`else
  localparam bit EchoEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StPark, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic              mem_mode_q, mem_mode_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready_q) begin
          we_d     = bus.req_we;
          addr_d   = bus.req_addr;
          remain_d = bus.req_we ? '0 : bus.req_len;
          wdata_d  = bus.req_wdata;
          state_d  = StPark;
        end
      end
      StPark: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == '0) begin
          if (we_q) begin
`ifdef STORE_ECHO_CHECK_EN
            rsp_rdata_d = bus.mem_rdata;
            rsp_err_d   = (bus.mem_rdata != wdata_q);
`else
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
`endif
          end else begin
            rsp_rdata_d = bus.mem_rdata;
            rsp_err_d   = 1'b0;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          if (remain_q != '0) begin
            remain_d = remain_q - LEN_W'(1);
            addr_d   = addr_q + ADDR_W'(1);  // wraps 31 -> 0
            state_d  = StPark;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of what the next state wants on the pins.
    req_ready_d    = (state_d == StIdle);
    busy_d         = (state_d != StIdle);
    rsp_valid_d    = (state_d == StResp);
    mem_address_d  = mem_address_q;
    mem_write_en_d = 1'b0;
    mem_mode_d     = 1'b1;
    mem_wdata_d    = mem_wdata_q;
    if (state_d == StPark) begin
      mem_address_d = ~addr_d;
    end
    if (state_d == StAccess) begin
      mem_address_d  = addr_d;
      mem_write_en_d = we_d;
      mem_mode_d     = we_d ? !EchoEn : 1'b0;
      if (we_d) begin
        mem_wdata_d = wdata_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      addr_q         <= '0;
      remain_q       <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      mem_address_q  <= '0;
      mem_write_en_q <= 1'b0;
      mem_mode_q     <= 1'b1;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      remain_q       <= remain_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      busy_q         <= busy_d;
      mem_address_q  <= mem_address_d;
      mem_write_en_q <= mem_write_en_d;
      mem_mode_q     <= mem_mode_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = busy_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_write_en = mem_write_en_q;
  assign bus.mem_mode     = mem_mode_q;
  assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + random test of mem_access_unit against a word-array reference
// model. Expected accesses and responses are queued at issue time and checked by a monitor.
module tb_mem_access_unit;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_LAT   = 2;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned WORDS     = 2 ** ADDR_W;
`ifdef STORE_ECHO_CHECK_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic              err;
    bit                first;
    int                acc_cyc;
  } rsp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  mem_access_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  rsp_t              exp_q[$];
  acc_t              acc_q[$];
  logic [DATA_W-1:0] mem_arr [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W-1:0] corrupt = '0;
  logic              load_mem = 1'b0;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                acc_total = 0;
  int                rsp_total = 0;
  logic              rst_last = 1'b1;
  bit                ready_rand = 1'b0;
  bit                stall_req = 1'b0;
  int                stall_cnt = 0;

  // Memory model: writes on the clock edge, read path is write-through so STORE_ECHO reads back.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_last <= rst;
    if (load_mem) mem_arr <= ref_mem;
    else if (bus.mem_write_en) mem_arr[bus.mem_address] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = (bus.mem_write_en ? bus.mem_wdata : mem_arr[bus.mem_address]) ^ corrupt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic              seen = 1'b0;
  logic [DATA_W-1:0] held_rdata;
  logic              held_err;
  logic              prev_acc = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [ADDR_W-1:0] park_exp;
  logic [1:0]        cmd_exp;
  int                acc_run = 0;
  logic              acc_now;
  rsp_t              er;
  acc_t              ea;

  always @(negedge clk) begin
    acc_now = bus.mem_write_en || !bus.mem_mode;
    if (rst_last) begin
      check("rst_flags", {bus.rsp_valid, bus.rsp_err, bus.busy, bus.req_ready, bus.mem_write_en,
                          bus.mem_mode}, 6'b000001);
      check("rst_rdata", bus.rsp_rdata, 0);
      check("rst_mem_addr", bus.mem_address, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      exp_q.delete();
      acc_q.delete();
      seen    = 1'b0;
      acc_now = 1'b0;
      acc_run = 0;
    end else begin
      check("ready_vs_busy", bus.req_ready, !bus.busy);
      if (acc_now && !prev_acc) begin
        acc_total++;
        acc_run = 1;
        if (acc_q.size() == 0) begin
          check("unexpected_access", 1, 0);
        end else begin
          ea       = acc_q.pop_front();
          park_exp = ~ea.addr;
          cmd_exp  = {ea.we, ea.we ? !ECHO : 1'b0};
          check("acc_addr", bus.mem_address, ea.addr);
          check("park_addr", prev_addr, park_exp);
          check("acc_cmd", {bus.mem_write_en, bus.mem_mode}, cmd_exp);
        end
      end else if (acc_now) begin
        acc_run++;
      end else if (prev_acc) begin
        check("acc_len", acc_run, MEM_LAT);
      end

      if (bus.rsp_valid && !seen) begin
        rsp_total++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          er = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, er.rdata);
          check("rsp_err", bus.rsp_err, er.err);
          if (er.first) check("latency", cyc + 1 - er.acc_cyc, 2 + MEM_LAT);
        end
        held_rdata = bus.rsp_rdata;
        held_err   = bus.rsp_err;
        seen       = 1'b1;
      end else if (bus.rsp_valid) begin
        check("rsp_hold", {bus.rsp_err, bus.rsp_rdata}, {held_err, held_rdata});
      end
      if (bus.rsp_valid && bus.rsp_ready) seen = 1'b0;
    end
    prev_acc  = acc_now;
    prev_addr = bus.mem_address;
  end

  // Response-ready driver
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && bus.rsp_valid) begin
        stall_req = 1'b0;
        stall_cnt = 3;
      end
      if (stall_cnt > 0) begin
        bus.rsp_ready = 1'b0;
        stall_cnt--;
      end else begin
        bus.rsp_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                       input logic [DATA_W-1:0] d);
    int n = 0;
    int t;
    logic [ADDR_W-1:0] ai;
    rsp_t r;
    acc_t x;
    @(negedge clk);
    while (!bus.req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", bus.req_ready, 1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.req_wdata = d;
    @(posedge clk);
    #1;
    t = cyc;
    bus.req_valid = 1'b0;
    check("req_ready_drop", bus.req_ready, 0);
    if (we) begin
      ref_mem[a] = d;
      x.addr = a;
      x.we   = 1'b1;
      acc_q.push_back(x);
      r.addr    = a;
      r.rdata   = ECHO ? (d ^ corrupt) : '0;
      r.err     = ECHO && (corrupt != '0);
      r.first   = 1'b1;
      r.acc_cyc = t;
      exp_q.push_back(r);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        ai     = a + ADDR_W'(i);
        x.addr = ai;
        x.we   = 1'b0;
        acc_q.push_back(x);
        r.addr    = ai;
        r.rdata   = ref_mem[ai];
        r.err     = 1'b0;
        r.first   = (i == 0);
        r.acc_cyc = t;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || acc_q.size() != 0 || !bus.req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_rsp_q", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int base;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = $urandom;
    load_mem = 1'b1;
    repeat (3) @(posedge clk);
    load_mem = 1'b0;
    @(negedge clk);
    check("ready_in_rst", bus.req_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", bus.req_ready, 1);

    // Store then load the same word
    issue(1'b1, 5'd3, 3'd0, 32'hDEADBEEF);
    issue(1'b0, 5'd3, 3'd0, '0);
    drain();
    // Back-to-back loads of one address: PARK must still move the address
    issue(1'b0, 5'd3, 3'd0, '0);
    issue(1'b0, 5'd3, 3'd0, '0);
    drain();
    // Wrapping burst with a 3-cycle consumer stall
    stall_req = 1'b1;
    issue(1'b0, 5'd30, 3'd3, '0);
    drain();

    // Reset during the second word of a 4-word burst
    base = acc_total;
    issue(1'b0, 5'd10, 3'd3, '0);
    n = 0;
    while (acc_total < base + 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("burst_reached_word2", acc_total, base + 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rsp_valid_in_rst", bus.rsp_valid, 0);
    rst = 1'b0;
    base = rsp_total;
    @(posedge clk);
    #1;
    check("ready_after_mid_rst", bus.req_ready, 1);
    repeat (20) @(posedge clk);
    check("no_rsp_after_rst", rsp_total, base);

`ifdef STORE_ECHO_CHECK_EN
    issue(1'b1, 5'd7, 3'd0, 32'h12345678);
    drain();
    corrupt = 32'h0000_0100;
    issue(1'b1, 5'd8, 3'd0, $urandom);
    drain();
    corrupt = '0;
`endif

    // Random traffic with a random consumer
    ready_rand = 1'b1;
    repeat (40) begin
      issue(1'($urandom_range(0, 1)), ADDR_W'($urandom), LEN_W'($urandom), $urandom);
    end
    drain();
    ready_rand = 1'b0;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
